// File: rtl/button_event_gen_if.sv
// button_event_gen_if
//   Bundles the switch-level input and the per-channel event outputs of
//   button_event_gen.
//   Two of the event names had to change: `release` and `repeat` are
//   SystemVerilog keywords, so those outputs are called `rls` and `rpt`.
//
//   in         : debounced switch levels, 1 = pressed (driven by master)
//   press      : 1-cycle pulse on press
//   rls        : 1-cycle pulse on release
//   click      : 1-cycle pulse on a release that comes before long_press
//   long_press : 1-cycle pulse when a hold reaches LONG_TICKS
//   rpt        : 1-cycle pulse every REPEAT_TICKS while held past long_press
//   held       : level, 1 while the channel is in HELD
interface button_event_gen_if #(parameter int WIDTH = 2);
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] press;
  logic [WIDTH-1:0] rls;
  logic [WIDTH-1:0] click;
  logic [WIDTH-1:0] long_press;
  logic [WIDTH-1:0] rpt;
  logic [WIDTH-1:0] held;

  modport master (output in, input press, rls, click, long_press, rpt, held);
  modport slave  (input in, output press, rls, click, long_press, rpt, held);
endinterface

// File: rtl/button_event_gen.sv
// button_event_gen
//   Turns debounced switch levels into 1-cycle event pulses. Every channel
//   is independent: it resynchronises its level into clk and then runs its
//   own IDLE/PRESSED/HELD state machine. All event outputs are registered.
//
//   clk     : system clock
//   reset_n : asynchronous active-low reset
//   bus     : button_event_gen_if.slave (in -> press/rls/click/long_press/rpt/held)

// One channel: synchroniser, edge detect, state machine, hold counter.
module button_event_lane #(
  parameter int LONG_TICKS   = 500000,
  parameter int REPEAT_TICKS = 100000,
  parameter int CW           = 19
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  output logic press,
  output logic rls,
  output logic click,
  output logic long_press,
  output logic rpt,
  output logic held
);
  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  // The counter holds cycles elapsed since the last press, long_press or
  // rpt pulse. A threshold is therefore reached one cycle before its pulse
  // appears, which is why the terminal counts are one less than the tick counts.
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] RPT_LAST  = (REPEAT_TICKS > 0) ? CW'(REPEAT_TICKS - 1) : '0;

  state_t        state_q, state_d;
  logic          s1, s2, prev;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_d, rls_d, click_d, long_d, rpt_d, held_d;
  logic          rise, fall;

  assign rise = s2 & ~prev;
  assign fall = ~s2 & prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0; s2 <= 1'b0; prev <= 1'b0;
      state_q <= IDLE; cnt_q <= '0;
      press <= 1'b0; rls <= 1'b0; click <= 1'b0;
      long_press <= 1'b0; rpt <= 1'b0; held <= 1'b0;
    end else begin
      s1 <= in; s2 <= s1; prev <= s2;
      state_q <= state_d; cnt_q <= cnt_d;
      press <= press_d; rls <= rls_d; click <= click_d;
      long_press <= long_d; rpt <= rpt_d; held <= held_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0; rls_d = 1'b0; click_d = 1'b0;
    long_d  = 1'b0; rpt_d = 1'b0;
    case (state_q)
      IDLE: if (rise) begin
        press_d = 1'b1;
        cnt_d   = '0;
        state_d = PRESSED;
      end
      // A fall is tested first so that it wins over a long_press or rpt
      // that would fire in the same cycle.
      PRESSED: if (fall) begin
        rls_d   = 1'b1;
        click_d = 1'b1;
        state_d = IDLE;
      end else if (cnt_q == LONG_LAST) begin
        long_d  = 1'b1;
        cnt_d   = '0;
        state_d = HELD;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      HELD: if (fall) begin
        rls_d   = 1'b1;
        state_d = IDLE;
      end else if (REPEAT_TICKS > 0) begin
        if (cnt_q == RPT_LAST) begin
          rpt_d = 1'b1;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // held follows the state being entered, so it drops on the rls cycle.
    held_d = (state_d == HELD);
  end
endmodule

module button_event_gen #(
  parameter int WIDTH        = 2,
  parameter int LONG_TICKS   = 500000,
  parameter int REPEAT_TICKS = 100000
) (
  input logic               clk,
  input logic               reset_n,
  button_event_gen_if.slave bus
);
  localparam int MAXT = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int CW   = $clog2(MAXT + 1);

  logic [WIDTH-1:0] press_v, rls_v, click_v, long_v, rpt_v, held_v;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    button_event_lane #(
      .LONG_TICKS(LONG_TICKS), .REPEAT_TICKS(REPEAT_TICKS), .CW(CW)
    ) u_lane (
      .clk(clk), .reset_n(reset_n), .in(bus.in[i]),
      .press(press_v[i]), .rls(rls_v[i]), .click(click_v[i]),
      .long_press(long_v[i]), .rpt(rpt_v[i]), .held(held_v[i])
    );
  end

  assign bus.press      = press_v;
  assign bus.rls        = rls_v;
  assign bus.click      = click_v;
  assign bus.long_press = long_v;
  assign bus.rpt        = rpt_v;
  assign bus.held       = held_v;
endmodule

// File: tb/tb_button_event_gen.sv
// tb_button_event_gen
//   Directed scenarios followed by random toggling. Expected outputs come
//   from a reference model that works on event times. It records the input
//   seen at each edge. The level the design acts on is the input from two
//   edges earlier. Each pulse is derived from the cycle distance to that
//   channel's press.
module tb_button_event_gen;
  localparam int W    = 2;
  localparam int LONG = 8;
  localparam int REP  = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  button_event_gen_if #(.WIDTH(W)) ifc ();
  button_event_gen #(.WIDTH(W), .LONG_TICKS(LONG), .REPEAT_TICKS(REP)) dut (
    .clk(clk), .reset_n(reset_n), .bus(ifc.slave)
  );

  int checks = 0;
  int errors = 0;
  int n = 0;                          // edge counter
  logic [W-1:0] h0, h1, h2, h3;       // input sampled at edges n, n-1, n-2, n-3
  int p_edge [W];                     // edge of each channel's last press pulse

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%b exp=%b edge=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic check_model();
    logic [W-1:0] e_press, e_rls, e_click, e_long, e_rpt, e_held;
    int d;
    e_press = '0; e_rls = '0; e_click = '0; e_long = '0; e_rpt = '0; e_held = '0;
    if (reset_n) begin
      for (int c = 0; c < W; c++) begin
        if (h2[c] && !h3[c]) begin
          e_press[c] = 1'b1;
          p_edge[c]  = n;
        end else if (!h2[c] && h3[c]) begin
          e_rls[c]   = 1'b1;
          e_click[c] = ((n - p_edge[c]) <= LONG);
        end else if (h2[c]) begin
          d = n - p_edge[c];
          e_long[c] = (d == LONG);
          e_rpt[c]  = (REP > 0) && (d > LONG) && (((d - LONG) % REP) == 0);
          e_held[c] = (d >= LONG);
        end
      end
    end
    chk("press", ifc.press, e_press);
    chk("release", ifc.rls, e_rls);
    chk("click", ifc.click, e_click);
    chk("long_press", ifc.long_press, e_long);
    chk("repeat", ifc.rpt, e_rpt);
    chk("held", ifc.held, e_held);
  endtask

  // Apply v before the next edge, then check the outputs 1 time unit after it.
  task automatic step(input logic [W-1:0] v);
    ifc.in = v;
    @(posedge clk);
    n++;
    if (!reset_n) begin
      h0 = '0; h1 = '0; h2 = '0; h3 = '0;
    end else begin
      h3 = h2; h2 = h1; h1 = h0; h0 = v;
    end
    #1;
    check_model();
  endtask

  task automatic steps(input logic [W-1:0] v, input int k);
    for (int i = 0; i < k; i++) step(v);
  endtask

  initial begin
    logic [W-1:0] cur;
    h0 = '0; h1 = '0; h2 = '0; h3 = '0;
    for (int c = 0; c < W; c++) p_edge[c] = 0;
    ifc.in = '0;

    // Reset with idle inputs, then 20 quiet cycles.
    steps(2'b00, 3);
    reset_n = 1'b1;
    steps(2'b00, 20);

    // Short click on channel 0.
    steps(2'b01, 5);
    steps(2'b00, 10);

    // Long hold: long_press, two repeats, then a release without click.
    steps(2'b01, 20);
    steps(2'b00, 10);

    // The fall lands on the long_press cycle, then on the first repeat cycle.
    steps(2'b01, 8);
    steps(2'b00, 10);
    steps(2'b01, 12);
    steps(2'b00, 10);

    // Both channels together. Channel 1 clicks while channel 0 goes long.
    steps(2'b11, 3);
    steps(2'b01, 27);
    steps(2'b00, 10);

    // Glitch of one cycle.
    steps(2'b01, 1);
    steps(2'b00, 6);

    // Reset asserted while channel 0 is HELD.
    steps(2'b01, 15);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_press", ifc.press, '0);
    chk("rst_release", ifc.rls, '0);
    chk("rst_click", ifc.click, '0);
    chk("rst_long", ifc.long_press, '0);
    chk("rst_repeat", ifc.rpt, '0);
    chk("rst_held", ifc.held, '0);
    steps(2'b01, 2);
    reset_n = 1'b1;
    steps(2'b01, 10);
    steps(2'b00, 8);

    // Random toggling on both channels.
    cur = '0;
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 9) == 0) cur[c] = ~cur[c];
      step(cur);
    end
    steps(2'b00, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/button_event_gen.md
Name: button_event_gen

Overview:
Converts debounced switch levels into one-cycle event pulses for control logic (UI state machines, menu navigation). Sits directly downstream of the switch debouncer, one instance per switch vector. Each channel independently reports press, release, short click, long press and auto-repeat. Its input comes from the debouncer's divided sample-clock domain, so every channel is resynchronised into clk first.

Parameters:
WIDTH, 2, number of independent channels
LONG_TICKS, 500000, clk cycles from press pulse to long_press pulse; legal range >= 2
REPEAT_TICKS, 100000, clk cycles between repeat pulses after long_press; 0 disables repeat

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
in  input  WIDTH  debounced switch levels, 1 = pressed
press  output  WIDTH  1-cycle pulse on channel press
release  output  WIDTH  1-cycle pulse on channel release
click  output  WIDTH  1-cycle pulse on release before long_press fired
long_press  output  WIDTH  1-cycle pulse when hold reaches LONG_TICKS
repeat  output  WIDTH  1-cycle pulse every REPEAT_TICKS while held past long_press
held  output  WIDTH  level, 1 while channel is in HELD state

Behaviour:
- Single clock domain clk. reset_n is asynchronous, active-low.
- Reset:
  - All outputs are 0.
  - Synchroniser flops, previous-level flop and counters are 0.
  - Every FSM is in IDLE.
  - Asserting reset mid-hold clears everything immediately. No release or click pulse is emitted afterwards.
- Per channel: two-flop synchroniser (s1, s2). lvl = s2. prev = lvl registered one cycle later.
- Edges: rise = lvl & ~prev; fall = ~lvl & prev.
- Latency: in rising before clk edge k gives press high for exactly the cycle after edge k+2. Release uses the same latency.
- If in is already 1 when reset deasserts, a press is still reported, because the flops reset to 0.
- FSM states IDLE, PRESSED, HELD. All outputs are registered pulses.
  - IDLE, rise: press=1, cnt cleared, goto PRESSED.
  - PRESSED, fall: release=1 and click=1 in the same cycle, goto IDLE.
  - PRESSED, lvl=1: cnt increments. At exactly LONG_TICKS cycles after the press-pulse cycle: long_press=1, held=1, cnt cleared, goto HELD.
  - HELD, lvl=1, REPEAT_TICKS>0: repeat=1 every REPEAT_TICKS cycles, measured from the long_press cycle; cnt wraps to 0 at each pulse.
  - HELD, lvl=1, REPEAT_TICKS=0: no repeat pulses. The counter holds and does not wrap.
  - HELD, fall: release=1, no click, held=0 in that same cycle, goto IDLE.
- Simultaneous events:
  - If fall coincides with the cycle long_press would fire, release and click win and long_press is not emitted.
  - If fall coincides with a repeat cycle, release wins and repeat is not emitted.
- Output exclusivity per channel per cycle:
  - press is exclusive with all other pulses.
  - click only ever pulses together with release.
  - long_press is never coincident with repeat.
- Counter width is $clog2(max(LONG_TICKS, REPEAT_TICKS)+1). It never overflows, because every threshold clears it.
- Channels share no state. Simultaneous events on different channels are all reported in the same cycle.
- A 1-cycle glitch on in (which the debouncer should not produce) is still processed faithfully: press, then release+click.

Test Plan:
(bench params WIDTH=2, LONG_TICKS=8, REPEAT_TICKS=4)
- Reset with in=0, release reset, hold 20 cycles -> all outputs 0 throughout, no pulses.
- in[0]=1 for 5 cycles then 0 -> press[0] 1 cycle; 5 cycles later release[0] and click[0] together. No long_press, held[0] stays 0.
- in[0]=1 for 20 cycles (press pulse at cycle P) -> long_press[0] and held[0] rise at P+8; repeat[0] at P+12, P+16, then release[0] without click; held[0]=0 on the release cycle.
- Release timed so fall hits the P+8 cycle -> release+click, no long_press. Repeat the test with release on the P+12 cycle -> release only, no repeat.
- in=2'b11 simultaneously, then drop in[1] after 3 cycles and in[0] after 30 cycles -> independent pulses per channel, and channel 1 click does not disturb channel 0 long_press or repeat.
- Assert reset_n=0 while channel 0 is HELD -> outputs 0 immediately; after reset release with in[0] still 1, a fresh press[0] appears 3 edges later.
